// File: rtl/fetch_sequencer.sv
// Program-counter sequencer for the instruction ROM: walks the PC one instruction per cycle,
// applies absolute/relative branches fed back from the decoder, and stops on halt or PC overflow.
module fetch_sequencer #(
    parameter int A     = 10,
    parameter int OFS_W = 6,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [A-1:0]     StartAddr,
    input  logic             Stall,
    input  logic             Halt,
    input  logic             BranchAbs,
    input  logic [A-1:0]     BranchTarget,
    input  logic             BranchRel,
    input  logic [OFS_W-1:0] RelOffset,
    output logic [A-1:0]     InstAddress,
    output logic             Running,
    output logic             Done,
    output logic             Fault,
    output logic [CNT_W-1:0] InstCount
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [A-1:0]     PC_MAX  = '1;
    localparam logic [A-1:0]     PC_ONE  = A'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [A-1:0]     pc_q, pc_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Two extra bits: the top bit flags a negative target, the next one a target past the ROM.
    logic [A+1:0] rel_sum;
    logic         rel_oob;
    logic [CNT_W-1:0] cnt_inc;

    assign rel_sum = {2'b00, pc_q} + {{(A + 2 - OFS_W){RelOffset[OFS_W-1]}}, RelOffset};
    assign rel_oob = rel_sum[A+1] | rel_sum[A];
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        running_d = running_q;
        done_d    = done_q;
        fault_d   = fault_q;
        cnt_d     = cnt_q;

        if (Start) begin
            state_d   = S_RUN;
            pc_d      = StartAddr;
            running_d = 1'b1;
            done_d    = 1'b0;
            fault_d   = 1'b0;
            cnt_d     = '0;
        end else if (state_q == S_RUN && !Stall) begin
            // Every non-stalled RUN cycle retires the instruction at PC, including the faulting one.
            cnt_d = cnt_inc;
            if (Halt) begin
                state_d   = S_HALTED;
                running_d = 1'b0;
                done_d    = 1'b1;
            end else if (BranchAbs) begin
                pc_d = BranchTarget;
            end else if (BranchRel) begin
                if (rel_oob) begin
                    state_d   = S_HALTED;
                    running_d = 1'b0;
                    done_d    = 1'b1;
                    fault_d   = 1'b1;
                end else begin
                    pc_d = rel_sum[A-1:0];
                end
            end else if (pc_q == PC_MAX) begin
                state_d   = S_HALTED;
                running_d = 1'b0;
                done_d    = 1'b1;
                fault_d   = 1'b1;
            end else begin
                pc_d = pc_q + PC_ONE;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            fault_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            running_q <= running_d;
            done_q    <= done_d;
            fault_q   <= fault_d;
            cnt_q     <= cnt_d;
        end
    end

    assign InstAddress = pc_q;
    assign Running     = running_q;
    assign Done        = done_q;
    assign Fault       = fault_q;
    assign InstCount   = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a table-driven decoder model feeds controls back from
// InstAddress, and observed address sequences/flags are checked against hand-computed values.
module tb_fetch_sequencer;

    localparam int A     = 10;
    localparam int OFS_W = 6;
    localparam int CNT_W = 16;

    logic             Clk;
    logic             Reset;
    logic             Start;
    logic [A-1:0]     StartAddr;
    logic             Stall;
    logic             Halt;
    logic             BranchAbs;
    logic [A-1:0]     BranchTarget;
    logic             BranchRel;
    logic [OFS_W-1:0] RelOffset;
    logic [A-1:0]     InstAddress;
    logic             Running;
    logic             Done;
    logic             Fault;
    logic [CNT_W-1:0] InstCount;

    // Program tables standing in for the decoder.
    logic             prog_halt [1024];
    logic             prog_abs  [1024];
    logic             prog_rel  [1024];
    logic [A-1:0]     prog_tgt  [1024];
    logic [OFS_W-1:0] prog_ofs  [1024];

    assign Halt         = prog_halt[InstAddress];
    assign BranchAbs    = prog_abs[InstAddress];
    assign BranchTarget = prog_tgt[InstAddress];
    assign BranchRel    = prog_rel[InstAddress];
    assign RelOffset    = prog_ofs[InstAddress];

    fetch_sequencer #(.A(A), .OFS_W(OFS_W), .CNT_W(CNT_W)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .StartAddr    (StartAddr),
        .Stall        (Stall),
        .Halt         (Halt),
        .BranchAbs    (BranchAbs),
        .BranchTarget (BranchTarget),
        .BranchRel    (BranchRel),
        .RelOffset    (RelOffset),
        .InstAddress  (InstAddress),
        .Running      (Running),
        .Done         (Done),
        .Fault        (Fault),
        .InstCount    (InstCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    int seq_q[$];
    int exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 1024; i++) begin
            prog_halt[i] = 1'b0;
            prog_abs[i]  = 1'b0;
            prog_rel[i]  = 1'b0;
            prog_tgt[i]  = '0;
            prog_ofs[i]  = '0;
        end
    endtask

    // Called at a falling edge; returns at the falling edge where PC == addr.
    task automatic start_prog(input int addr);
        Start     = 1'b1;
        StartAddr = A'(addr);
        @(negedge Clk);
        Start = 1'b0;
    endtask

    // Records each executed address until Done rises or the cycle budget runs out.
    task automatic collect();
        seq_q.delete();
        for (int i = 0; i < 64 && !Done; i++) begin
            if (Running) seq_q.push_back(int'(InstAddress));
            @(negedge Clk);
        end
    endtask

    task automatic compare_seq(input string tag);
        check_eq({tag, "_len"}, seq_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < seq_q.size(); i++)
            check_eq($sformatf("%s_pc%0d", tag, i), seq_q[i], exp_q[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        StartAddr = '0;
        Stall = 1'b0;
        clear_prog();
        #2 Reset = 1'b0;
        repeat (2) @(negedge Clk);
        check_eq("rst_pc", InstAddress, 0);
        check_eq("rst_running", Running, 0);
        check_eq("rst_done", Done, 0);
        check_eq("rst_fault", Fault, 0);
        check_eq("rst_count", InstCount, 0);
        Reset = 1'b1;
        @(negedge Clk);
        check_eq("idle_running", Running, 0);

        // Straight-line run halting at 5.
        prog_halt[5] = 1'b1;
        start_prog(0);
        collect();
        exp_q = '{0, 1, 2, 3, 4, 5};
        compare_seq("t1");
        check_eq("t1_done", Done, 1);
        check_eq("t1_fault", Fault, 0);
        check_eq("t1_count", InstCount, 6);
        check_eq("t1_pc", InstAddress, 5);
        repeat (2) @(negedge Clk);
        check_eq("t1_pc_held", InstAddress, 5);
        check_eq("t1_done_held", Done, 1);
        $display("t1 straight run: checks=%0d failures=%0d", n_checks, n_fail);

        // Absolute branch 3 -> 12, halt at 14.
        clear_prog();
        prog_abs[3] = 1'b1;
        prog_tgt[3] = A'(12);
        prog_halt[14] = 1'b1;
        start_prog(0);
        collect();
        exp_q = '{0, 1, 2, 3, 12, 13, 14};
        compare_seq("t2");
        check_eq("t2_count", InstCount, 7);
        check_eq("t2_fault", Fault, 0);
        $display("t2 abs branch: checks=%0d failures=%0d", n_checks, n_fail);

        // Relative branch -3 from 10 lands on 7.
        clear_prog();
        prog_rel[10] = 1'b1;
        prog_ofs[10] = 6'h3D;
        prog_halt[7] = 1'b1;
        start_prog(10);
        collect();
        exp_q = '{10, 7};
        compare_seq("t3a");
        check_eq("t3a_count", InstCount, 2);
        check_eq("t3a_fault", Fault, 0);

        // Relative branch -8 from 2 goes negative: fault.
        clear_prog();
        prog_rel[2] = 1'b1;
        prog_ofs[2] = 6'h38;
        start_prog(2);
        collect();
        exp_q = '{2};
        compare_seq("t3b");
        check_eq("t3b_done", Done, 1);
        check_eq("t3b_fault", Fault, 1);
        check_eq("t3b_pc", InstAddress, 2);
        check_eq("t3b_count", InstCount, 1);
        $display("t3 rel branch: checks=%0d failures=%0d", n_checks, n_fail);

        // Stall at the halt instruction.
        clear_prog();
        prog_halt[4] = 1'b1;
        start_prog(0);
        repeat (4) @(negedge Clk);
        check_eq("t4_pc_pre", InstAddress, 4);
        check_eq("t4_count_pre", InstCount, 4);
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check_eq($sformatf("t4_stall%0d_pc", i), InstAddress, 4);
            check_eq($sformatf("t4_stall%0d_count", i), InstCount, 4);
            check_eq($sformatf("t4_stall%0d_done", i), Done, 0);
        end
        Stall = 1'b0;
        @(negedge Clk);
        check_eq("t4_done", Done, 1);
        check_eq("t4_pc", InstAddress, 4);
        check_eq("t4_count", InstCount, 5);
        check_eq("t4_fault", Fault, 0);
        $display("t4 stall: checks=%0d failures=%0d", n_checks, n_fail);

        // Running off the top of the address space.
        clear_prog();
        start_prog(1020);
        collect();
        exp_q = '{1020, 1021, 1022, 1023};
        compare_seq("t5");
        check_eq("t5_done", Done, 1);
        check_eq("t5_fault", Fault, 1);
        check_eq("t5_pc", InstAddress, 1023);
        check_eq("t5_count", InstCount, 4);
        $display("t5 top overflow: checks=%0d failures=%0d", n_checks, n_fail);

        // Restart mid-run, then async reset mid-run.
        clear_prog();
        start_prog(0);
        repeat (9) @(negedge Clk);
        check_eq("t6_pc9", InstAddress, 9);
        Start     = 1'b1;
        StartAddr = A'(2);
        @(negedge Clk);
        Start = 1'b0;
        check_eq("t6_restart_pc", InstAddress, 2);
        check_eq("t6_restart_count", InstCount, 0);
        check_eq("t6_restart_running", Running, 1);
        check_eq("t6_restart_fault", Fault, 0);
        repeat (3) @(negedge Clk);
        check_eq("t6_pc5", InstAddress, 5);
        check_eq("t6_count3", InstCount, 3);
        #2 Reset = 1'b0;
        #1;
        check_eq("t6_rst_pc", InstAddress, 0);
        check_eq("t6_rst_running", Running, 0);
        check_eq("t6_rst_count", InstCount, 0);
        check_eq("t6_rst_done", Done, 0);
        check_eq("t6_rst_fault", Fault, 0);
        @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        check_eq("t6_idle_running", Running, 0);
        check_eq("t6_idle_pc", InstAddress, 0);
        $display("t6 restart/reset: checks=%0d failures=%0d", n_checks, n_fail);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
